// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Lets the CPU instruction-fetch port and the load/store port share one
//   single-port memory. At most one access is outstanding. The data port has
//   priority, but the instruction port always wins once the data port has
//   taken STARVE_LIMIT grants in a row while instruction was waiting. A
//   timeout counter turns a hung memory into an error response on the owning
//   port.
//
// Ports
//   clk, rst             clock (rising edge), synchronous active-low reset
//   i_req/i_addr         instruction read request
//   i_ready              same-cycle accept pulse for the instruction port
//   i_rvalid/i_rdata/i_err  instruction response (err = timed out)
//   d_req/d_we/d_addr/d_wdata  data request (d_we==0 is a load)
//   d_ready              same-cycle accept pulse for the data port
//   d_rvalid/d_rdata/d_err  data response / store ack (err = timed out)
//   mem_req/mem_addr/mem_we/mem_wdata  registered memory request
//   mem_gnt/mem_rvalid/mem_rdata       memory handshake and read data
//   owner_o              owner of the current access: 0 = instr, 1 = data
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_ready,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_err,
  input  logic                    d_req,
  input  logic [DATA_WIDTH/8-1:0] d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_ready,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_err,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    owner_o
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t          state_q;
  logic [SW-1:0]   streak_q;
  logic [TW-1:0]   timer_q;

  logic idle_ok, starved, grant_d, grant_i, timeout;

  // Arbitration is combinational so the winner's ready pulses in the IDLE
  // cycle that sees the request; held off entirely while reset is asserted.
  assign idle_ok = rst & (state_q == IDLE);
  assign starved = (streak_q == SW'(STARVE_LIMIT));
  assign grant_d = idle_ok & d_req & ~(i_req & starved);
  assign grant_i = idle_ok & i_req & ~grant_d;
  assign i_ready = grant_i;
  assign d_ready = grant_d;

  // The timer reaches TIMEOUT_CYCLES-1 on the edge that aborts, so REQ+RESP
  // last TIMEOUT_CYCLES-1 cycles at most. Abort beats a same-cycle gnt/rvalid.
  assign timeout = (state_q != IDLE) & (timer_q == TW'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      timer_q   <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= '0;
      mem_wdata <= '0;
      owner_o   <= 1'b0;
      i_rvalid  <= 1'b0;
      i_err     <= 1'b0;
      i_rdata   <= '0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      // response strobes are single-cycle pulses
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_i | grant_d) begin
            state_q   <= REQ;
            timer_q   <= '0;
            mem_req   <= 1'b1;
            owner_o   <= grant_d;
            mem_addr  <= grant_d ? d_addr  : i_addr;
            mem_we    <= grant_d ? d_we    : {BW{1'b0}};
            mem_wdata <= grant_d ? d_wdata : {DATA_WIDTH{1'b0}};
            // streak counts data grants that made a waiting fetch wait longer
            if (grant_d & i_req)
              streak_q <= starved ? streak_q : streak_q + SW'(1);
            else
              streak_q <= '0;
          end
        end
        REQ, RESP: begin
          timer_q <= timer_q + TW'(1);
          if (timeout) begin
            state_q <= IDLE;
            mem_req <= 1'b0;
            if (owner_o) begin
              d_rvalid <= 1'b1;
              d_err    <= 1'b1;
              d_rdata  <= '0;
            end else begin
              i_rvalid <= 1'b1;
              i_err    <= 1'b1;
              i_rdata  <= '0;
            end
          end else if (state_q == REQ) begin
            if (mem_gnt) begin
              state_q <= RESP;
              mem_req <= 1'b0;
            end
          end else if (mem_rvalid) begin
            state_q <= IDLE;
            if (owner_o) begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_rdata;
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= mem_rdata;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
